alarm_set_ctrl: RTL and testbench
=================================

# alarm_set_ctrl

Button-driven configuration controller for the alarm clock. It sequences the user through setting the current time and the alarm time, one BCD digit at a time. It drives the `*_init` and `*_bud` digit buses of the alarm core and issues a one-cycle load strobe for the edited time. It also owns the alarm-enable flag and sits between the board-level debounced buttons and the alarm core.

## Interface
Parameters:
- `TIMEOUT_S`, default 30: seconds of inactivity in an edit state before the controller returns to RUN.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset. One clock; reset is asynchronous and active-low.
- `mode_p` in 1: debounced single-cycle pulse that cycles the edit mode.
- `next_p` in 1: single-cycle pulse that advances to the next digit.
- `inc_p` in 1: single-cycle pulse that increments the selected digit.
- `alarm_tog_p` in 1: single-cycle pulse that toggles alarm enable (RUN only).
- `sec_tick` in 1: single-cycle pulse, once per second.
- `hourdec_now`, `hourone_now`, `mindec_now`, `minone_now` in 4 each: current time from the core.
- `hourdec_init`, `hourone_init`, `mindec_init`, `minone_init` out 4 each: time edit buffer.
- `time_load` out 1: one-cycle strobe; the core loads the `*_init` buses.
- `hourdec_bud`, `hourone_bud`, `mindec_bud`, `minone_bud` out 4 each: alarm time.
- `bud_en` out 1: alarm enable.
- `edit_state` out 2: 0 = RUN, 1 = SET_TIME, 2 = SET_ALARM.
- `digit_sel` out 2: selected digit. 0 = hourdec, 1 = hourone, 2 = mindec, 3 = minone.

## Operation
- **FSM transitions on `mode_p`:**
  - RUN → SET_TIME: copy all `*_now` digits into the init buffer; `digit_sel` = 0.
  - SET_TIME → SET_ALARM: pulse `time_load`; `digit_sel` = 0.
  - SET_ALARM → RUN.
- **`next_p` (edit states only):** `digit_sel` advances 0→1→2→3→0.
- **`inc_p` (edit states only):** increments the selected digit of the active buffer (init in SET_TIME, bud in SET_ALARM). Wrap rules:
  - hourdec: 0..2, then wraps to 0.
  - hourone: 0..9 when hourdec < 2; 0..3 when hourdec = 2.
  - mindec: 0..5.
  - minone: 0..9.
- **Hour clamp:** if hourdec is incremented to 2 while hourone > 3, hourone is set to 3 in the same cycle.
- **Ignored pulses:** `next_p` and `inc_p` in RUN are ignored. `alarm_tog_p` in an edit state is ignored.
- **Simultaneous pulses:** priority is `mode_p` > `next_p` > `inc_p`. Only one pulse is acted on per cycle; lower-priority pulses are dropped.
- **Timeout counter:** cleared on any accepted pulse and on entering an edit state. It increments on `sec_tick` only in edit states. When it reaches `TIMEOUT_S`, the FSM returns to RUN:
  - From SET_TIME the edit is aborted: no `time_load`.
  - From SET_ALARM the bud digits are kept.
- **Alarm buffer:** the bud digits are edited in place, are persistent, and are never reloaded from the core.
- **Outputs in RUN:** init buffer holds its last value; `time_load` = 0.

## Timing
- All outputs are registered. An accepted pulse in cycle N is visible at outputs in cycle N+1.
- `time_load` is high for exactly one cycle: the cycle in which `edit_state` first reads 2. The `*_init` buses are stable in that cycle and remain unchanged until the next SET_TIME entry.
- **Timeout at boundary:** a `sec_tick` that brings the count to `TIMEOUT_S` takes effect the next cycle. If an accepted button pulse arrives in the same cycle, the pulse wins and the counter clears.
- **Reset values (asynchronous assertion, mid-operation included):**
  - `edit_state` = RUN, `digit_sel` = 0.
  - All init and bud digits = 0.
  - `bud_en` = 0, `time_load` = 0, timeout counter = 0.
- Reset never generates a `time_load`.
- Timeout counter width: $clog2(`TIMEOUT_S`+1).

## Structure
- **Package `alarm_pkg`:**
  - `ctrl_state_e` enum: RUN, SET_TIME, SET_ALARM.
  - `digit_idx_e` enum: HOURDEC, HOURONE, MINDEC, MINONE.
  - Digit maxima as constants: 2, 9, 3 (hourone when hourdec = 2), 5, 9.
  - `bcd_time_t` packed struct of four 4-bit digits.
- **Sub-module `bcd_digit_inc`:** combinational. Given a `bcd_time_t` and a `digit_idx_e`, it returns the incremented time with the wrap and clamp rules applied. One instance is shared by both edit buffers through a state-selected mux.

## Test plan
- **Enter SET_TIME:** reset, `*_now` = 1,2,3,4, `mode_p` → `edit_state` = 1, init = 1,2,3,4, `digit_sel` = 0.
- **Hour clamp:** init 1,7,5,9; `inc_p` on hourdec → 2,3,5,9. One further `inc_p` on hourdec → 0,3,5,9.
- **Minute wraps:** `next_p` ×2, `inc_p` on mindec 5 → 0. `next_p`, `inc_p` on minone 9 → 0. Another `next_p` → `digit_sel` wraps to 0.
- **Load and alarm edit:** `mode_p` from SET_TIME → `time_load` high exactly 1 cycle with the buffer held. In SET_ALARM, `inc_p` ×7 on hourone → bud 0,7,0,0. `mode_p` → RUN. `alarm_tog_p` → `bud_en` = 1.
- **Timeout:** `TIMEOUT_S` = 3. In SET_TIME, 3 `sec_tick` with no buttons → RUN, `time_load` never asserted. Repeat with `inc_p` coinciding with the 3rd tick → stays in SET_TIME.
- **Priority and reset:** `mode_p`, `next_p` and `inc_p` in the same cycle in SET_TIME → state advances, digits unchanged. `rstn` low mid-SET_ALARM → all outputs at their reset values immediately.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and digit limits for the alarm clock configuration path.
package alarm_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        HOURDEC = 2'd0,
        HOURONE = 2'd1,
        MINDEC  = 2'd2,
        MINONE  = 2'd3
    } digit_idx_e;

    // Largest legal value of each BCD digit; hourone shrinks to 3 in the 20s.
    localparam logic [3:0] HOURDEC_MAX    = 4'd2;
    localparam logic [3:0] HOURONE_MAX    = 4'd9;
    localparam logic [3:0] HOURONE_MAX_20 = 4'd3;
    localparam logic [3:0] MINDEC_MAX     = 4'd5;
    localparam logic [3:0] MINONE_MAX     = 4'd9;

    typedef struct packed {
        logic [3:0] hourdec;
        logic [3:0] hourone;
        logic [3:0] mindec;
        logic [3:0] minone;
    } bcd_time_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// Combinational increment of one digit of an HH:MM BCD time with wrap and hour clamp.
module bcd_digit_inc
    import alarm_pkg::*;
(
    input  bcd_time_t  time_in,
    input  digit_idx_e idx,
    output bcd_time_t  time_out
);

    logic [3:0] hourone_max;

    assign hourone_max = (time_in.hourdec == HOURDEC_MAX) ? HOURONE_MAX_20 : HOURONE_MAX;

    // Bump the selected digit, wrap at its maximum, and clamp hourone when entering the 20s.
    always_comb begin
        time_out = time_in;
        case (idx)
            HOURDEC: begin
                if (time_in.hourdec >= HOURDEC_MAX) begin
                    time_out.hourdec = 4'd0;
                end else begin
                    time_out.hourdec = time_in.hourdec + 4'd1;
                    if ((time_out.hourdec == HOURDEC_MAX) && (time_in.hourone > HOURONE_MAX_20)) begin
                        time_out.hourone = HOURONE_MAX_20;
                    end
                end
            end
            HOURONE: begin
                if (time_in.hourone >= hourone_max) time_out.hourone = 4'd0;
                else                                time_out.hourone = time_in.hourone + 4'd1;
            end
            MINDEC: begin
                if (time_in.mindec >= MINDEC_MAX) time_out.mindec = 4'd0;
                else                              time_out.mindec = time_in.mindec + 4'd1;
            end
            default: begin
                if (time_in.minone >= MINONE_MAX) time_out.minone = 4'd0;
                else                              time_out.minone = time_in.minone + 4'd1;
            end
        endcase
    end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven time/alarm setting controller sitting between debounced buttons and the alarm core.
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mode_p,
    input  logic       next_p,
    input  logic       inc_p,
    input  logic       alarm_tog_p,
    input  logic       sec_tick,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    output logic [3:0] hourdec_init,
    output logic [3:0] hourone_init,
    output logic [3:0] mindec_init,
    output logic [3:0] minone_init,
    output logic       time_load,
    output logic [3:0] hourdec_bud,
    output logic [3:0] hourone_bud,
    output logic [3:0] mindec_bud,
    output logic [3:0] minone_bud,
    output logic       bud_en,
    output logic [1:0] edit_state,
    output logic [1:0] digit_sel
);

    localparam int CNT_W = $clog2(TIMEOUT_S + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_S - 1);

    ctrl_state_e      state_q, state_d;
    digit_idx_e       sel_q, sel_d;
    bcd_time_t        init_q, init_d;
    bcd_time_t        bud_q, bud_d;
    logic             en_q, en_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bcd_time_t        inc_src, inc_res;
    bcd_time_t        now_time;

    assign now_time = '{hourdec: hourdec_now, hourone: hourone_now,
                        mindec: mindec_now, minone: minone_now};

    // One incrementer serves both buffers; the active edit state picks which one it sees.
    assign inc_src = (state_q == SET_ALARM) ? bud_q : init_q;

    bcd_digit_inc u_inc (
        .time_in  (inc_src),
        .idx      (sel_q),
        .time_out (inc_res)
    );

    // Register every piece of controller state so all outputs come straight from flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            sel_q   <= HOURDEC;
            init_q  <= '0;
            bud_q   <= '0;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            init_q  <= init_d;
            bud_q   <= bud_d;
            en_q    <= en_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
        end
    end

    // Act on at most one pulse per cycle (mode > next > inc); an idle tick advances the timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        init_d  = init_q;
        bud_d   = bud_q;
        en_d    = en_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mode_p) begin
                    state_d = SET_TIME;
                    init_d  = now_time;
                    sel_d   = HOURDEC;
                    cnt_d   = '0;
                end else if (alarm_tog_p) begin
                    en_d = ~en_q;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (mode_p) begin
                    if (state_q == SET_TIME) begin
                        state_d = SET_ALARM;
                        load_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                    sel_d = HOURDEC;
                    cnt_d = '0;
                end else if (next_p) begin
                    sel_d = digit_idx_e'(sel_q + 2'd1);
                    cnt_d = '0;
                end else if (inc_p) begin
                    if (state_q == SET_TIME) init_d = inc_res;
                    else                     bud_d  = inc_res;
                    cnt_d = '0;
                end else if (sec_tick) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = RUN;
                        sel_d   = HOURDEC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                sel_d   = HOURDEC;
                cnt_d   = '0;
            end
        endcase
    end

    assign hourdec_init = init_q.hourdec;
    assign hourone_init = init_q.hourone;
    assign mindec_init  = init_q.mindec;
    assign minone_init  = init_q.minone;
    assign hourdec_bud  = bud_q.hourdec;
    assign hourone_bud  = bud_q.hourone;
    assign mindec_bud   = bud_q.mindec;
    assign minone_bud   = bud_q.minone;
    assign time_load    = load_q;
    assign bud_en       = en_q;
    assign edit_state   = state_q;
    assign digit_sel    = sel_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed scoreboard bench for alarm_set_ctrl with a short timeout.
module tb_alarm_set_ctrl;

    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       mode_p = 1'b0, next_p = 1'b0, inc_p = 1'b0, alarm_tog_p = 1'b0, sec_tick = 1'b0;
    logic [3:0] hourdec_now = 4'd1, hourone_now = 4'd2, mindec_now = 4'd3, minone_now = 4'd4;
    logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
    logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
    logic       time_load, bud_en;
    logic [1:0] edit_state, digit_sel;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [1:0]  st;
        logic [1:0]  sel;
        logic [15:0] init;
        logic [15:0] bud;
        logic        en;
        logic        tl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        want;
    exp_t        rst_want;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    alarm_set_ctrl #(.TIMEOUT_S(TMO)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mode_p       (mode_p),
        .next_p       (next_p),
        .inc_p        (inc_p),
        .alarm_tog_p  (alarm_tog_p),
        .sec_tick     (sec_tick),
        .hourdec_now  (hourdec_now),
        .hourone_now  (hourone_now),
        .mindec_now   (mindec_now),
        .minone_now   (minone_now),
        .hourdec_init (hourdec_init),
        .hourone_init (hourone_init),
        .mindec_init  (mindec_init),
        .minone_init  (minone_init),
        .time_load    (time_load),
        .hourdec_bud  (hourdec_bud),
        .hourone_bud  (hourone_bud),
        .mindec_bud   (mindec_bud),
        .minone_bud   (minone_bud),
        .bud_en       (bud_en),
        .edit_state   (edit_state),
        .digit_sel    (digit_sel)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index used to match scoreboard entries to the cycle they describe.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare every DUT output against one expected snapshot.
    task automatic checkOutput(input exp_t e);
        logic [15:0] act_init, act_bud;
        act_init = {hourdec_init, hourone_init, mindec_init, minone_init};
        act_bud  = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};
        vectors++;
        if (edit_state !== e.st || digit_sel !== e.sel || act_init !== e.init ||
            act_bud !== e.bud || bud_en !== e.en || time_load !== e.tl) begin
            miscompares++;
            $display("[TB] FAIL %s: got st=%0d sel=%0d init=%h bud=%h en=%b load=%b, want st=%0d sel=%0d init=%h bud=%h en=%b load=%b",
                     e.name, edit_state, digit_sel, act_init, act_bud, bud_en, time_load,
                     e.st, e.sel, e.init, e.bud, e.en, e.tl);
        end
    endtask

    // Drive one cycle of pulses and queue the outputs expected after the next edge.
    task automatic applyStimulus(input string name, input logic m, input logic n,
                                 input logic i, input logic t, input logic s);
        exp_t e;
        mode_p = m; next_p = n; inc_p = i; alarm_tog_p = t; sec_tick = s;
        e      = want;
        e.name = name;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        mode_p = 1'b0; next_p = 1'b0; inc_p = 1'b0; alarm_tog_p = 1'b0; sec_tick = 1'b0;
    endtask

    // Monitor: sample away from the active edge and retire whatever is due this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            checkOutput(sb_q[0]);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        rst_want = '{cyc: 0, name: "reset", st: 2'd0, sel: 2'd0, init: 16'h0000,
                     bud: 16'h0000, en: 1'b0, tl: 1'b0};
        want = rst_want;

        repeat (2) @(posedge clk);
        #1;
        checkOutput(rst_want);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Enter SET_TIME capturing the live time.
        want.st = 2'd1; want.init = 16'h1234; want.sel = 2'd0;
        applyStimulus("enter_set_time", 1, 0, 0, 0, 0);

        // Walk the buffer to 17:59.
        want.sel = 2'd1;
        applyStimulus("next_to_hourone", 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            want.init[11:8] = 4'(3 + k);
            applyStimulus("inc_hourone", 0, 0, 1, 0, 0);
        end
        want.sel = 2'd2;
        applyStimulus("next_to_mindec", 0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            want.init[7:4] = 4'(4 + k);
            applyStimulus("inc_mindec", 0, 0, 1, 0, 0);
        end
        want.sel = 2'd3;
        applyStimulus("next_to_minone", 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            want.init[3:0] = 4'(5 + k);
            applyStimulus("inc_minone", 0, 0, 1, 0, 0);
        end
        want.sel = 2'd0;
        applyStimulus("sel_wrap_1759", 0, 1, 0, 0, 0);

        // Hour clamp then hourdec wrap.
        want.init = 16'h2359;
        applyStimulus("hour_clamp", 0, 0, 1, 0, 0);
        want.init = 16'h0359;
        applyStimulus("hourdec_wrap", 0, 0, 1, 0, 0);

        // Minute wraps and digit select wrap.
        want.sel = 2'd1;
        applyStimulus("next_a", 0, 1, 0, 0, 0);
        want.sel = 2'd2;
        applyStimulus("next_b", 0, 1, 0, 0, 0);
        want.init = 16'h0309;
        applyStimulus("mindec_wrap", 0, 0, 1, 0, 0);
        want.sel = 2'd3;
        applyStimulus("next_c", 0, 1, 0, 0, 0);
        want.init = 16'h0300;
        applyStimulus("minone_wrap", 0, 0, 1, 0, 0);
        want.sel = 2'd0;
        applyStimulus("sel_wrap", 0, 1, 0, 0, 0);

        // Load strobe on entry to SET_ALARM, for one cycle only.
        want.st = 2'd2; want.tl = 1'b1;
        applyStimulus("time_load_pulse", 1, 0, 0, 0, 0);
        want.tl = 1'b0;
        applyStimulus("time_load_drop", 0, 0, 0, 0, 0);

        // Alarm edit: hourone to 7, toggle ignored while editing.
        want.sel = 2'd1;
        applyStimulus("alarm_next", 0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            want.bud[11:8] = 4'(1 + k);
            applyStimulus("alarm_inc_hourone", 0, 0, 1, 0, 0);
        end
        applyStimulus("tog_ignored_in_edit", 0, 0, 0, 1, 0);
        want.st = 2'd0; want.sel = 2'd0;
        applyStimulus("back_to_run", 1, 0, 0, 0, 0);
        applyStimulus("next_ignored_in_run", 0, 1, 0, 0, 0);
        applyStimulus("inc_ignored_in_run", 0, 0, 1, 0, 0);
        want.en = 1'b1;
        applyStimulus("alarm_enable", 0, 0, 0, 1, 0);

        // Timeout from SET_TIME: third idle tick returns to RUN without a load.
        want.st = 2'd1; want.init = 16'h1234;
        applyStimulus("tmo_enter", 1, 0, 0, 0, 0);
        applyStimulus("tmo_tick1", 0, 0, 0, 0, 1);
        applyStimulus("tmo_tick2", 0, 0, 0, 0, 1);
        want.st = 2'd0;
        applyStimulus("tmo_tick3_run", 0, 0, 0, 0, 1);
        applyStimulus("tmo_no_load", 0, 0, 0, 0, 0);

        // Button coinciding with the third tick wins and restarts the count.
        want.st = 2'd1;
        applyStimulus("tmo2_enter", 1, 0, 0, 0, 0);
        applyStimulus("tmo2_tick1", 0, 0, 0, 0, 1);
        applyStimulus("tmo2_tick2", 0, 0, 0, 0, 1);
        want.init = 16'h2234;
        applyStimulus("tmo2_inc_with_tick3", 0, 0, 1, 0, 1);
        applyStimulus("tmo2_tick_a", 0, 0, 0, 0, 1);
        applyStimulus("tmo2_tick_b", 0, 0, 0, 0, 1);
        want.st = 2'd0;
        applyStimulus("tmo2_tick_c_run", 0, 0, 0, 0, 1);

        // Simultaneous pulses: mode wins, digits untouched.
        want.st = 2'd1; want.init = 16'h1234;
        applyStimulus("prio_enter", 1, 0, 0, 0, 0);
        want.sel = 2'd1;
        applyStimulus("prio_next", 0, 1, 0, 0, 0);
        want.st = 2'd2; want.sel = 2'd0; want.tl = 1'b1;
        applyStimulus("prio_all_three", 1, 1, 1, 0, 0);
        want.tl = 1'b0;
        applyStimulus("prio_load_drop", 0, 0, 0, 0, 0);
        want.bud = 16'h1700;
        applyStimulus("alarm_inc_hourdec", 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of SET_ALARM.
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput(rst_want);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        want = rst_want;
        applyStimulus("after_reset_idle", 0, 0, 0, 0, 0);
        applyStimulus("after_reset_idle2", 0, 0, 0, 0, 0);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d entries left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
